// File: rtl/mccpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, instruction classes,
// ALU codes, datapath select codes and the Op/Funct constants of the supported ISA.
package mccpu_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsAluR, ClsAluI, ClsLoad, ClsStore, ClsBranch, ClsJump, ClsJreg, ClsIllegal
  } iclass_e;

  // ALU operation codes, shared with the single-cycle datapath
  localparam logic [3:0] AluNop  = 4'd0;
  localparam logic [3:0] AluAdd  = 4'd1;
  localparam logic [3:0] AluSub  = 4'd2;
  localparam logic [3:0] AluAnd  = 4'd3;
  localparam logic [3:0] AluOr   = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluNor  = 4'd6;
  localparam logic [3:0] AluSlt  = 4'd7;
  localparam logic [3:0] AluSltu = 4'd8;
  localparam logic [3:0] AluSll  = 4'd9;
  localparam logic [3:0] AluSrl  = 4'd10;
  localparam logic [3:0] AluSra  = 4'd11;
  localparam logic [3:0] AluLui  = 4'd12;

  localparam logic [1:0] NpcPlus4  = 2'b00;
  localparam logic [1:0] NpcBranch = 2'b01;
  localparam logic [1:0] NpcJump   = 2'b10;
  localparam logic [1:0] NpcReg    = 2'b11;

  localparam logic [1:0] GprRd = 2'b00;
  localparam logic [1:0] GprRt = 2'b01;
  localparam logic [1:0] GprRa = 2'b10;

  localparam logic [1:0] WdAlu = 2'b00;
  localparam logic [1:0] WdMem = 2'b01;
  localparam logic [1:0] WdPc  = 2'b10;

  localparam logic [1:0] MemByte = 2'b01;
  localparam logic [1:0] MemHalf = 2'b10;
  localparam logic [1:0] MemWord = 2'b11;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLb    = 6'h20;
  localparam logic [5:0] OpLh    = 6'h21;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpLbu   = 6'h24;
  localparam logic [5:0] OpLhu   = 6'h25;
  localparam logic [5:0] OpSb    = 6'h28;
  localparam logic [5:0] OpSh    = 6'h29;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

endpackage

// File: rtl/mccpu_idec.sv
// Combinational instruction decoder: classifies Op/Funct and produces the static datapath
// controls (ALU op, operand selects, access size) that the FSM gates by state.
module mccpu_idec
  import mccpu_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_e    cls_o,
  output logic [3:0] aluop_o,
  output logic       extop_o,
  output logic       alusrc_o,
  output logic       aregsel_o,
  output logic [1:0] memop_o,
  output logic       link_o,
  output logic       signed_ld_o
);

  always_comb begin
    cls_o       = ClsIllegal;
    aluop_o     = AluNop;
    extop_o     = 1'b0;
    alusrc_o    = 1'b0;
    aregsel_o   = 1'b0;
    memop_o     = 2'b00;
    link_o      = 1'b0;
    signed_ld_o = 1'b0;
    case (op_i)
      OpRtype: begin
        cls_o = ClsAluR;
        case (funct_i)
          FnAdd, FnAddu: aluop_o = AluAdd;
          FnSub, FnSubu: aluop_o = AluSub;
          FnAnd:         aluop_o = AluAnd;
          FnOr:          aluop_o = AluOr;
          FnXor:         aluop_o = AluXor;
          FnNor:         aluop_o = AluNor;
          FnSlt:         aluop_o = AluSlt;
          FnSltu:        aluop_o = AluSltu;
          FnSll:         begin aluop_o = AluSll; aregsel_o = 1'b1; end
          FnSrl:         begin aluop_o = AluSrl; aregsel_o = 1'b1; end
          FnSra:         begin aluop_o = AluSra; aregsel_o = 1'b1; end
          FnSllv:        aluop_o = AluSll;
          FnSrlv:        aluop_o = AluSrl;
          FnSrav:        aluop_o = AluSra;
          FnJr:          cls_o = ClsJreg;
          FnJalr:        begin cls_o = ClsJreg; link_o = 1'b1; end
          default:       cls_o = ClsIllegal;
        endcase
      end
      OpJ:   cls_o = ClsJump;
      OpJal: begin cls_o = ClsJump; link_o = 1'b1; end
      OpBeq, OpBne: begin
        cls_o   = ClsBranch;
        aluop_o = AluSub;
        extop_o = 1'b1;
      end
      OpAddi: begin cls_o = ClsAluI; aluop_o = AluAdd; alusrc_o = 1'b1; extop_o = 1'b1; end
      OpSlti: begin cls_o = ClsAluI; aluop_o = AluSlt; alusrc_o = 1'b1; extop_o = 1'b1; end
      OpAndi: begin cls_o = ClsAluI; aluop_o = AluAnd; alusrc_o = 1'b1; end
      OpOri:  begin cls_o = ClsAluI; aluop_o = AluOr;  alusrc_o = 1'b1; end
      OpLui:  begin cls_o = ClsAluI; aluop_o = AluLui; alusrc_o = 1'b1; end
      OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw: begin
        cls_o    = op_i[3] ? ClsStore : ClsLoad;
        aluop_o  = AluAdd;
        alusrc_o = 1'b1;
        extop_o  = 1'b1;
        // op[1:0] selects the size within both the load and the store groups
        case (op_i[1:0])
          2'b00:   memop_o = MemByte;
          2'b01:   memop_o = MemHalf;
          default: memop_o = MemWord;
        endcase
        signed_ld_o = (op_i == OpLb) || (op_i == OpLh);
      end
      default: cls_o = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/mccpu_ctrl.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with a memory ready
// handshake, illegal-instruction trap and a wrapping retired-instruction counter.
module mccpu_ctrl
  import mccpu_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4,
  parameter bit          MEM_HS  = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_rdy,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               EXTOp,
  output logic               ALUSrc,
  output logic               AregSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         NPCOp,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic [1:0]         memOp,
  output logic [2:0]         state,
  output logic               illegal,
  output logic [CNT_W-1:0]   retire_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             mem_done;

  iclass_e    dec_cls;
  logic [3:0] dec_aluop;
  logic       dec_ext, dec_alusrc, dec_areg, dec_link, unused_signed_ld;
  logic [1:0] dec_memop;

  mccpu_idec u_idec (
    .op_i        (Op),
    .funct_i     (Funct),
    .cls_o       (dec_cls),
    .aluop_o     (dec_aluop),
    .extop_o     (dec_ext),
    .alusrc_o    (dec_alusrc),
    .aregsel_o   (dec_areg),
    .memop_o     (dec_memop),
    .link_o      (dec_link),
    .signed_ld_o (unused_signed_ld)
  );

  assign mem_done = mem_rdy | ~MEM_HS;

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrc   = 1'b0;
    AregSel  = 1'b0;
    ALUOp    = '0;
    NPCOp    = NpcPlus4;
    GPRSel   = GprRd;
    WDSel    = WdAlu;
    memOp    = 2'b00;
    illegal  = 1'b0;
    // Reset masks every output, so a reset mid-access never leaks a write
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          MemRead = 1'b1;
          memOp   = MemWord;
          if (mem_done) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = StDecode;
          end
        end
        StDecode: begin
          if (dec_cls == ClsIllegal) begin
            state_d = StTrap;
          end else if (dec_cls == ClsJump) begin
            PCWrite  = 1'b1;
            NPCOp    = NpcJump;
            RegWrite = dec_link;
            if (dec_link) begin
              GPRSel = GprRa;
              WDSel  = WdPc;
            end
            state_d = StFetch;
            retire  = 1'b1;
          end else begin
            state_d = StExec;
          end
        end
        StExec: begin
          ALUOp   = ALUOP_W'(dec_aluop);
          ALUSrc  = dec_alusrc;
          EXTOp   = dec_ext;
          AregSel = dec_areg;
          case (dec_cls)
            ClsBranch: begin
              PCWrite = (Op == OpBne) ? ~Zero : Zero;
              NPCOp   = NpcBranch;
              state_d = StFetch;
              retire  = 1'b1;
            end
            ClsJreg: begin
              PCWrite  = 1'b1;
              NPCOp    = NpcReg;
              RegWrite = dec_link;
              if (dec_link) begin
                GPRSel = GprRa;
                WDSel  = WdPc;
              end
              state_d = StFetch;
              retire  = 1'b1;
            end
            ClsLoad, ClsStore: state_d = StMem;
            default:           state_d = StWb;
          endcase
        end
        StMem: begin
          memOp = dec_memop;
          if (dec_cls == ClsStore) begin
            MemWrite = 1'b1;
            if (mem_done) begin
              state_d = StFetch;
              retire  = 1'b1;
            end
          end else begin
            MemRead = 1'b1;
            if (mem_done) state_d = StWb;
          end
        end
        StWb: begin
          RegWrite = 1'b1;
          GPRSel   = (dec_cls == ClsAluR) ? GprRd : GprRt;
          WDSel    = (dec_cls == ClsLoad) ? WdMem : WdAlu;
          state_d  = StFetch;
          retire   = 1'b1;
        end
        StTrap:  illegal = 1'b1;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign state      = rst ? 3'd0 : state_q;
  assign retire_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Bench for mccpu_ctrl: per-instruction expected cycle traces built from the ISA rules,
// compared cycle by cycle; plus reset, trap and counter-wrap scenarios.
module tb_mccpu_ctrl;
  import mccpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       Zero, mem_rdy;
  logic       IRWrite, PCWrite, MemRead, MemWrite, RegWrite, EXTOp, ALUSrc, AregSel, illegal;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp, GPRSel, WDSel, memOp;
  logic [2:0] state;
  logic [15:0] retire_cnt;

  logic       rst2;
  logic [5:0] op2, funct2;
  logic       zero2, rdy2;
  logic       irw2, pcw2, mrd2, mwr2, rgw2, ext2, asrc2, areg2, ill2;
  logic [3:0] alu2;
  logic [1:0] npc2, gsel2, wsel2, mop2;
  logic [2:0] st2;
  logic [3:0] cnt2;

  mccpu_ctrl #(.ALUOP_W(4), .MEM_HS(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_rdy(mem_rdy),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUSrc(ALUSrc), .AregSel(AregSel), .ALUOp(ALUOp),
    .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel), .memOp(memOp), .state(state),
    .illegal(illegal), .retire_cnt(retire_cnt)
  );

  mccpu_ctrl #(.ALUOP_W(4), .MEM_HS(1'b0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .Op(op2), .Funct(funct2), .Zero(zero2), .mem_rdy(rdy2),
    .IRWrite(irw2), .PCWrite(pcw2), .MemRead(mrd2), .MemWrite(mwr2),
    .RegWrite(rgw2), .EXTOp(ext2), .ALUSrc(asrc2), .AregSel(areg2), .ALUOp(alu2),
    .NPCOp(npc2), .GPRSel(gsel2), .WDSel(wsel2), .memOp(mop2), .state(st2),
    .illegal(ill2), .retire_cnt(cnt2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        irw, pcw, mrd, mwr, rgw, ext, asrc, areg;
    logic [3:0]  aluop;
    logic [1:0]  npc, gsel, wsel, mop;
    logic        ill;
    logic [15:0] cnt;
  } snap_t;

  localparam int KAluR = 0, KAluI = 1, KLoad = 2, KStore = 3, KBeq = 4, KBne = 5;
  localparam int KJ = 6, KJal = 7, KJr = 8, KJalr = 9, KIll = 10;

  snap_t       exp_q[$];
  snap_t       obs_q[$];
  logic        rdy_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned model_cnt = 0;

  logic [5:0] r_functs [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2A,
                                6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09};
  logic [5:0] i_ops [17] = '{6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F, 6'h23, 6'h20, 6'h21, 6'h24,
                             6'h25, 6'h2B, 6'h28, 6'h29, 6'h04, 6'h05, 6'h02, 6'h03};

  function automatic snap_t sample();
    snap_t s;
    s.st = state; s.irw = IRWrite; s.pcw = PCWrite; s.mrd = MemRead; s.mwr = MemWrite;
    s.rgw = RegWrite; s.ext = EXTOp; s.asrc = ALUSrc; s.areg = AregSel; s.aluop = ALUOp;
    s.npc = NPCOp; s.gsel = GPRSel; s.wsel = WDSel; s.mop = memOp; s.ill = illegal;
    s.cnt = retire_cnt;
    return s;
  endfunction

  function automatic snap_t blank(input int st);
    snap_t s = '0;
    s.st  = 3'(st);
    s.cnt = 16'(model_cnt);
    return s;
  endfunction

  // Reference ISA table: kind and EXEC-time ALU controls per instruction
  task automatic ref_decode(input logic [5:0] op, input logic [5:0] fn, output int kind,
                            output logic [3:0] alu, output logic ext, output logic asrc,
                            output logic areg, output logic [1:0] mop);
    kind = KIll; alu = AluNop; ext = 0; asrc = 0; areg = 0; mop = 2'b00;
    case (op)
      6'h00: begin
        kind = KAluR;
        case (fn)
          6'h20, 6'h21: alu = AluAdd;
          6'h22, 6'h23: alu = AluSub;
          6'h24: alu = AluAnd;
          6'h25: alu = AluOr;
          6'h26: alu = AluXor;
          6'h27: alu = AluNor;
          6'h2A: alu = AluSlt;
          6'h2B: alu = AluSltu;
          6'h00: begin alu = AluSll; areg = 1; end
          6'h02: begin alu = AluSrl; areg = 1; end
          6'h03: begin alu = AluSra; areg = 1; end
          6'h04: alu = AluSll;
          6'h06: alu = AluSrl;
          6'h07: alu = AluSra;
          6'h08: kind = KJr;
          6'h09: kind = KJalr;
          default: kind = KIll;
        endcase
      end
      6'h02: kind = KJ;
      6'h03: kind = KJal;
      6'h04: begin kind = KBeq; alu = AluSub; ext = 1; end
      6'h05: begin kind = KBne; alu = AluSub; ext = 1; end
      6'h08: begin kind = KAluI; alu = AluAdd; asrc = 1; ext = 1; end
      6'h0A: begin kind = KAluI; alu = AluSlt; asrc = 1; ext = 1; end
      6'h0C: begin kind = KAluI; alu = AluAnd; asrc = 1; end
      6'h0D: begin kind = KAluI; alu = AluOr; asrc = 1; end
      6'h0F: begin kind = KAluI; alu = AluLui; asrc = 1; end
      6'h20, 6'h24: begin kind = KLoad; alu = AluAdd; asrc = 1; ext = 1; mop = 2'b01; end
      6'h21, 6'h25: begin kind = KLoad; alu = AluAdd; asrc = 1; ext = 1; mop = 2'b10; end
      6'h23: begin kind = KLoad; alu = AluAdd; asrc = 1; ext = 1; mop = 2'b11; end
      6'h28: begin kind = KStore; alu = AluAdd; asrc = 1; ext = 1; mop = 2'b01; end
      6'h29: begin kind = KStore; alu = AluAdd; asrc = 1; ext = 1; mop = 2'b10; end
      6'h2B: begin kind = KStore; alu = AluAdd; asrc = 1; ext = 1; mop = 2'b11; end
      default: kind = KIll;
    endcase
  endtask

  // Expected per-cycle trace of one instruction; wf/wm are FETCH/MEM wait cycles
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                             input int wm, input logic zero, output int kind);
    snap_t s;
    logic [3:0] alu;
    logic ext, asrc, areg;
    logic [1:0] mop;
    ref_decode(op, fn, kind, alu, ext, asrc, areg, mop);
    exp_q.delete();
    rdy_q.delete();
    for (int i = 0; i <= wf; i++) begin
      s = blank(0); s.mrd = 1; s.mop = 2'b11;
      if (i == wf) begin s.irw = 1; s.pcw = 1; end
      exp_q.push_back(s); rdy_q.push_back(i == wf);
    end
    s = blank(1);
    if (kind == KJ || kind == KJal) begin s.pcw = 1; s.npc = 2'b10; end
    if (kind == KJal) begin s.rgw = 1; s.gsel = 2'b10; s.wsel = 2'b10; end
    exp_q.push_back(s); rdy_q.push_back(1'($urandom_range(0, 1)));
    if (kind == KJ || kind == KJal) begin model_cnt = (model_cnt + 1) % 65536; return; end
    if (kind == KIll) begin
      for (int i = 0; i < 10; i++) begin
        s = blank(5); s.ill = 1;
        exp_q.push_back(s); rdy_q.push_back(1'($urandom_range(0, 1)));
      end
      return;
    end
    s = blank(2); s.aluop = alu; s.ext = ext; s.asrc = asrc; s.areg = areg;
    if (kind == KBeq || kind == KBne) begin
      s.pcw = (kind == KBeq) ? zero : !zero; s.npc = 2'b01;
    end
    if (kind == KJr || kind == KJalr) begin s.pcw = 1; s.npc = 2'b11; end
    if (kind == KJalr) begin s.rgw = 1; s.gsel = 2'b10; s.wsel = 2'b10; end
    exp_q.push_back(s); rdy_q.push_back(1'($urandom_range(0, 1)));
    if (kind >= KBeq) begin model_cnt = (model_cnt + 1) % 65536; return; end
    if (kind == KLoad || kind == KStore) begin
      for (int i = 0; i <= wm; i++) begin
        s = blank(3); s.mop = mop;
        if (kind == KLoad) s.mrd = 1; else s.mwr = 1;
        exp_q.push_back(s); rdy_q.push_back(i == wm);
      end
      if (kind == KStore) begin model_cnt = (model_cnt + 1) % 65536; return; end
    end
    s = blank(4); s.rgw = 1;
    s.gsel = (kind == KAluR) ? 2'b00 : 2'b01;
    s.wsel = (kind == KLoad) ? 2'b01 : 2'b00;
    exp_q.push_back(s); rdy_q.push_back(1'($urandom_range(0, 1)));
    model_cnt = (model_cnt + 1) % 65536;
  endtask

  // Plays the first n steps of the current trace and records the observed outputs
  task automatic drive_trace(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                             input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      Op = op; Funct = fn; Zero = zero; mem_rdy = rdy_q[i];
      #1;
      obs_q.push_back(sample());
      @(negedge clk);
    end
  endtask

  task automatic run_and_compare(input string name, input logic [5:0] op, input logic [5:0] fn,
                                 input int wf, input int wm, input logic zero, output int kind);
    model_instr(op, fn, wf, wm, zero, kind);
    drive_trace(op, fn, zero, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s op=%h fn=%h step %0d: got %h required %h", name, op, fn, i,
                 obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    snap_t s;
    rst = 1; Op = OpSw; Funct = 6'h3F; Zero = 1; mem_rdy = 1;
    @(negedge clk);
    #1;
    checks++;
    if (sample() !== snap_t'('0)) begin
      failures++; $display("FAIL reset_outputs: got %h required 0", sample());
    end
    rst = 0; mem_rdy = 0; model_cnt = 0;
    #1;
    s = blank(0); s.mrd = 1; s.mop = 2'b11;
    checks++;
    if (sample() !== s) begin
      failures++; $display("FAIL reset_fetch: got %h required %h", sample(), s);
    end
  endtask

  task automatic test_alu_add();
    int kind;
    run_and_compare("add", OpRtype, FnAdd, 0, 0, 0, kind);
    #1;
    checks++;
    if (retire_cnt !== 16'(model_cnt) || state !== 3'd0) begin
      failures++;
      $display("FAIL add_retire: got cnt=%0d state=%0d required cnt=%0d state=0",
               retire_cnt, state, model_cnt);
    end
  endtask

  task automatic test_load_wait();
    int kind;
    run_and_compare("lw_wait3", OpLw, 6'h00, 0, 3, 0, kind);
    run_and_compare("lbu_fetchwait", OpLbu, 6'h11, 2, 1, 1, kind);
  endtask

  task automatic test_branch();
    int kind;
    run_and_compare("beq_z1", OpBeq, 6'h00, 0, 0, 1, kind);
    run_and_compare("beq_z0", OpBeq, 6'h00, 0, 0, 0, kind);
    run_and_compare("bne_z1", OpBne, 6'h00, 1, 0, 1, kind);
    run_and_compare("bne_z0", OpBne, 6'h00, 0, 0, 0, kind);
  endtask

  task automatic test_jumps();
    int kind;
    run_and_compare("jal", OpJal, 6'h00, 0, 0, 0, kind);
    run_and_compare("j", OpJ, 6'h15, 1, 0, 1, kind);
    run_and_compare("jr", OpRtype, FnJr, 0, 0, 0, kind);
    run_and_compare("jalr", OpRtype, FnJalr, 0, 0, 1, kind);
  endtask

  task automatic test_store();
    int kind;
    run_and_compare("sw", OpSw, 6'h00, 0, 0, 0, kind);
    run_and_compare("sh_wait", OpSh, 6'h00, 1, 2, 0, kind);
    run_and_compare("sb", OpSb, 6'h00, 0, 1, 1, kind);
  endtask

  task automatic pulse_reset(input string name);
    snap_t s;
    rst = 1; mem_rdy = 1;
    #1;
    checks++;
    if (sample() !== snap_t'('0)) begin
      failures++; $display("FAIL %s_in_reset: got %h required 0", name, sample());
    end
    @(negedge clk);
    rst = 0; mem_rdy = 0; model_cnt = 0;
    #1;
    s = blank(0); s.mrd = 1; s.mop = 2'b11;
    checks++;
    if (sample() !== s) begin
      failures++; $display("FAIL %s_after_reset: got %h required %h", name, sample(), s);
    end
  endtask

  task automatic test_random();
    int kind;
    logic [5:0] op, fn;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        op = OpRtype; fn = r_functs[$urandom_range(0, 17)];
      end else begin
        op = i_ops[$urandom_range(0, 16)]; fn = 6'($urandom);
      end
      run_and_compare("rand_legal", op, fn, $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), kind);
    end
    for (int n = 0; n < 6; n++) begin
      run_and_compare("rand_any", 6'($urandom), 6'($urandom), $urandom_range(0, 1),
                      $urandom_range(0, 1), 1'($urandom_range(0, 1)), kind);
      if (kind == KIll) pulse_reset("rand_trap");
    end
  endtask

  task automatic test_illegal();
    int kind;
    run_and_compare("ill_op3f", 6'h3F, 6'h00, 0, 0, 0, kind);
    pulse_reset("trap_op3f");
    run_and_compare("ill_funct01", OpRtype, 6'h01, 0, 0, 0, kind);
    pulse_reset("trap_funct01");
    run_and_compare("ill_addiu", 6'h09, 6'h00, 1, 0, 0, kind);
    pulse_reset("trap_addiu");
  endtask

  task automatic test_reset_mid_mem();
    int kind;
    snap_t s;
    model_instr(OpSb, 6'h00, 0, 5, 0, kind);
    drive_trace(OpSb, 6'h00, 1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL sb_pre_reset step %0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    pulse_reset("sb_mid_mem");
    for (int i = 0; i < 4; i++) begin
      mem_rdy = 0;
      #1;
      s = blank(0); s.mrd = 1; s.mop = 2'b11;
      checks++;
      if (sample() !== s) begin
        failures++; $display("FAIL sb_abandoned cycle %0d: got %h required %h", i, sample(), s);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    op2 = OpJal; funct2 = 6'h00; zero2 = 0; rdy2 = 0;
    @(negedge clk);
    rst2 = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if ({st2, irw2, pcw2, mrd2, mwr2, rgw2, mop2, npc2} !== 12'b000_111_00_11_00 ||
          cnt2 !== 4'(i)) begin
        failures++;
        $display("FAIL wrap_fetch %0d: got st=%0d irw=%b cnt=%0d required st=0 irw=1 cnt=%0d",
                 i, st2, irw2, cnt2, i);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({st2, pcw2, npc2, rgw2, gsel2, wsel2, ext2, asrc2, areg2, alu2, ill2, irw2, mrd2,
           mwr2} !== 22'b001_1_10_1_10_10_000_0000_0_0_0_0) begin
        failures++;
        $display("FAIL wrap_decode %0d: got st=%0d pcw=%b npc=%b rgw=%b required 1/1/10/1",
                 i, st2, pcw2, npc2, rgw2);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (cnt2 !== 4'd0 || st2 !== 3'd0) begin
      failures++; $display("FAIL wrap_count: got cnt=%0d st=%0d required cnt=0 st=0", cnt2, st2);
    end
  endtask

  initial begin
    rst2 = 1; op2 = 0; funct2 = 0; zero2 = 0; rdy2 = 0;
    test_reset();
    test_alu_add();
    test_load_wait();
    test_branch();
    test_jumps();
    test_store();
    test_random();
    test_illegal();
    test_reset_mid_mem();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mccpu_ctrl.md
Name: mccpu_ctrl

Overview:
Multicycle control unit for the MIPS core. It replaces the single-cycle decoder and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Memory accesses wait on a ready handshake, so latency can vary. It decodes the same Op/Funct instruction set, adds an illegal-instruction trap, and counts retired instructions.

Parameters:
ALUOP_W, 4, width of ALUOp; codes are taken from the shared package and are identical to the single-cycle encoding.
MEM_HS, 1, 1 = FETCH and MEM wait for mem_rdy; 0 = memory always completes in one cycle and mem_rdy is ignored.
CNT_W, 16, width of retire_cnt.

Ports:
clk  in  1  clock.
rst  in  1  reset; one clock, synchronous and active-high.
Op  in  6  opcode field from the IR.
Funct  in  6  funct field from the IR.
Zero  in  1  ALU zero flag.
mem_rdy  in  1  memory completed the current access.
IRWrite  out  1  load the instruction register.
PCWrite  out  1  update the PC.
MemRead  out  1  memory read request (instruction or data).
MemWrite  out  1  data memory write request.
RegWrite  out  1  register file write.
EXTOp  out  1  1 = sign-extend the immediate.
ALUSrc  out  1  1 = ALU B operand is the immediate.
AregSel  out  1  1 = ALU A operand is shamt (sll/srl/sra).
ALUOp  out  ALUOP_W  ALU operation.
NPCOp  out  2  next-PC select: 00 = +4, 01 = branch, 10 = jump, 11 = register (jr/jalr).
GPRSel  out  2  write register select: 00 = rd, 01 = rt, 10 = $31.
WDSel  out  2  write data select: 00 = ALU, 01 = MEM, 10 = PC.
memOp  out  2  access size: 01 = byte, 10 = half, 11 = word.
state  out  3  current FSM state, for debug.
illegal  out  1  high while in TRAP.
retire_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Supported set: the existing ISA. R-type: add, addu, sub, subu, and, or, nor, xor, slt, sltu, sll, srl, sra, sllv, srlv, srav, jr, jalr. I-type: addi, andi, ori, slti, lui, lw, lb, lh, lbu, lhu, sw, sb, sh, beq, bne. J-type: j, jal.
- Any other Op, or any other Funct when Op = 0, is illegal.
- State encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- Outputs are combinational from the state and the decoded fields. Every output not listed for a state is 0.
- Reset:
  - Sampled at the clk edge: state <= FETCH, retire_cnt <= 0.
  - While rst is high, all outputs are forced to 0, including write enables.
  - Reset in any state, including mid-MEM, abandons the current instruction; no partial writes are issued after the reset edge.
- FETCH:
  - MemRead = 1, memOp = 11.
  - On mem_rdy (always, if MEM_HS = 0): IRWrite = 1, PCWrite = 1, NPCOp = 00; next state DECODE.
  - Otherwise hold FETCH.
- DECODE:
  - Illegal instruction -> TRAP, with no writes.
  - j: PCWrite = 1, NPCOp = 10 -> FETCH; retires.
  - jal: same as j, plus RegWrite = 1, GPRSel = 10, WDSel = 10; retires.
  - All other instructions -> EXEC.
- EXEC:
  - ALUOp, ALUSrc, EXTOp and AregSel are driven per the single-cycle decode table.
  - beq: PCWrite = Zero, NPCOp = 01 -> FETCH; retires.
  - bne: PCWrite = ~Zero, NPCOp = 01 -> FETCH; retires.
  - jr: PCWrite = 1, NPCOp = 11 -> FETCH; retires.
  - jalr: as jr, plus RegWrite = 1, GPRSel = 10, WDSel = 10; retires.
  - Loads and stores -> MEM. ALUOp = add, ALUSrc = 1, EXTOp = 1.
  - ALU R-type and I-type instructions -> WB.
- MEM:
  - Loads: MemRead = 1 and memOp per size, held until mem_rdy, then -> WB.
  - Stores: MemWrite = 1 and memOp per size, held until mem_rdy, then -> FETCH; retires.
  - mem_rdy arriving in the same cycle the request rises completes in one cycle.
- WB:
  - RegWrite = 1 for exactly one cycle.
  - GPRSel = 01 for I-type, 00 for R-type.
  - WDSel = 01 for loads, 00 otherwise.
  - Next state FETCH; retires.
- TRAP:
  - illegal = 1, all enables 0.
  - Stays in TRAP until rst.
- Retire:
  - retire_cnt increments by 1 on the edge of each retiring transition.
  - It wraps modulo 2^CNT_W with no saturation.
- Latency in cycles, with zero wait states:
  - j/jal: 2.
  - Branch, jr, jalr: 3.
  - ALU instruction: 4.
  - Store: 4.
  - Load: 5.
  - Each wait cycle adds 1.
- Op and Funct must be stable from DECODE onward. IRWrite is the only IR update, so this holds by construction.

Decomposition:
- Package mccpu_ctrl_pkg holds:
  - State enum.
  - ALUOp codes.
  - NPCOp, GPRSel, WDSel and memOp codes.
  - Opcode and funct constants.
- One combinational sub-module, mccpu_idec:
  - Maps Op/Funct to an instruction class (alu_r, alu_i, load, store, branch, jump, jreg, illegal).
  - Also produces ALUOp, EXTOp, ALUSrc, AregSel, memOp, link and signed_ld.
- The FSM and retire counter stay in mccpu_ctrl.

Test Plan:
1. Reset, then add (Op = 0, Funct = 0x20) with mem_rdy = 1 -> state sequence 0,1,2,4,0; ALUOp = add code in EXEC; RegWrite = 1 only in WB with GPRSel = 00; retire_cnt = 1.
2. lw (Op = 0x23) with mem_rdy low for 3 MEM cycles -> MemRead high 4 cycles in MEM, memOp = 11; WB has WDSel = 01, GPRSel = 01; total 8 cycles.
3. beq (Op = 0x04) with Zero = 1 -> PCWrite = 1, NPCOp = 01 in EXEC. Repeat with Zero = 0 -> PCWrite = 0 in EXEC. Both retire.
4. jal (Op = 0x03) -> DECODE cycle has PCWrite = 1, NPCOp = 10, RegWrite = 1, GPRSel = 10, WDSel = 10; next state FETCH.
5. Op = 0x3F -> TRAP with illegal = 1 and no enables for 10 cycles; rst pulse -> FETCH, illegal = 0, retire_cnt = 0.
6. sb (Op = 0x28) in MEM with mem_rdy = 0, rst asserted -> all outputs 0 during reset, state = FETCH after the edge, no MemWrite afterwards. Separately, with MEM_HS = 0, 2^CNT_W retires wrap retire_cnt to 0.
